// File: rtl/operand_latch.sv
// operand_latch: registers both register-file read operands into the decode/execute boundary.
// Optional feature macro OPERAND_BYPASS_EN enables write-back bypass on load and held-operand refresh.
module operand_latch #(
    parameter int WIDTH     = 32,
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [REG_BITS-1:0]  ctrl_readRegA,
    input  logic [REG_BITS-1:0]  ctrl_readRegB,
    input  logic [WIDTH-1:0]     data_readRegA,
    input  logic [WIDTH-1:0]     data_readRegB,
    input  logic                 ctrl_writeEnable,
    input  logic [REG_BITS-1:0]  ctrl_writeReg,
    input  logic [WIDTH-1:0]     data_writeReg,
    output logic                 out_valid,
    output logic [REG_BITS-1:0]  out_regA,
    output logic [REG_BITS-1:0]  out_regB,
    output logic [WIDTH-1:0]     out_dataA,
    output logic [WIDTH-1:0]     out_dataB,
    output logic [CNT_WIDTH-1:0] stall_count
);

    logic                 valid_q, valid_d;
    logic [REG_BITS-1:0]  rega_q, rega_d;
    logic [REG_BITS-1:0]  regb_q, regb_d;
    logic [WIDTH-1:0]     dataa_q, dataa_d;
    logic [WIDTH-1:0]     datab_q, datab_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 load_hit_a, load_hit_b;
    logic                 hold_hit_a, hold_hit_b;
    logic [WIDTH-1:0]     load_a, load_b;

`ifdef OPERAND_BYPASS_EN
    logic                 wr_live;

    // Write-back matches against incoming indices and held indices; reg 0 never matches.
    always_comb begin
        wr_live    = ctrl_writeEnable && (ctrl_writeReg != '0);
        load_hit_a = wr_live && (ctrl_writeReg == ctrl_readRegA);
        load_hit_b = wr_live && (ctrl_writeReg == ctrl_readRegB);
        hold_hit_a = wr_live && (ctrl_writeReg == rega_q);
        hold_hit_b = wr_live && (ctrl_writeReg == regb_q);
    end
`else
    logic                 unused_wr;

    // Without bypass the write port is ignored entirely.
    always_comb begin
        unused_wr  = ^{ctrl_writeEnable, ctrl_writeReg, data_writeReg};
        load_hit_a = 1'b0;
        load_hit_b = 1'b0;
        hold_hit_a = 1'b0;
        hold_hit_b = 1'b0;
    end
`endif

    // Operand selection for a load: reg 0 reads zero, else bypass, else read port.
    always_comb begin
        load_a = data_readRegA;
        load_b = data_readRegB;
        if (ctrl_readRegA == '0) begin
            load_a = '0;
        end else if (load_hit_a) begin
            load_a = data_writeReg;
        end
        if (ctrl_readRegB == '0) begin
            load_b = '0;
        end else if (load_hit_b) begin
            load_b = data_writeReg;
        end
    end

    // Next-state: flush beats stall beats load; reset handled in the flop block.
    always_comb begin
        valid_d = valid_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            rega_d  = '0;
            regb_d  = '0;
            dataa_d = '0;
            datab_d = '0;
        end else if (stall) begin
            if (valid_q && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (hold_hit_a) begin
                dataa_d = data_writeReg;
            end
            if (hold_hit_b) begin
                datab_d = data_writeReg;
            end
        end else begin
            valid_d = in_valid;
            rega_d  = ctrl_readRegA;
            regb_d  = ctrl_readRegB;
            dataa_d = load_a;
            datab_d = load_b;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            rega_q  <= '0;
            regb_q  <= '0;
            dataa_q <= '0;
            datab_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_regA    = rega_q;
    assign out_regB    = regb_q;
    assign out_dataA   = dataa_q;
    assign out_dataB   = datab_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_operand_latch.sv
// tb_operand_latch: directed stimulus, behavioural model checked every cycle,
// plus literal expectations at key points.
module tb_operand_latch;

    localparam int W  = 32;
    localparam int RB = 5;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, stall, flush;
    logic [RB-1:0] ctrl_readRegA, ctrl_readRegB, ctrl_writeReg;
    logic [W-1:0]  data_readRegA, data_readRegB, data_writeReg;
    logic          ctrl_writeEnable;
    logic          out_valid;
    logic [RB-1:0] out_regA, out_regB;
    logic [W-1:0]  out_dataA, out_dataB;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    operand_latch #(.WIDTH(W), .REG_BITS(RB), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .out_valid(out_valid),
        .out_regA(out_regA), .out_regB(out_regB),
        .out_dataA(out_dataA), .out_dataB(out_dataB),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

`ifdef OPERAND_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Behavioural model of the stage contents.
    bit          chk_en = 1'b0;
    bit          m_valid;
    int unsigned m_regA, m_regB, m_cnt;
    logic [W-1:0] m_dataA, m_dataB;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] operand(int unsigned idx, logic [W-1:0] rd);
        if (idx == 0) return '0;
        if (BYP && ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
        return rd;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            chk_en  = 1'b1;
            m_valid = 0; m_regA = 0; m_regB = 0;
            m_dataA = '0; m_dataB = '0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_regA = 0; m_regB = 0;
            m_dataA = '0; m_dataB = '0;
        end else if (stall) begin
            if (m_valid && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            if (BYP && ctrl_writeEnable && ctrl_writeReg != 0) begin
                if (ctrl_writeReg == m_regA) m_dataA = data_writeReg;
                if (ctrl_writeReg == m_regB) m_dataB = data_writeReg;
            end
        end else begin
            m_valid = in_valid;
            m_regA  = ctrl_readRegA;
            m_regB  = ctrl_readRegB;
            m_dataA = operand(ctrl_readRegA, data_readRegA);
            m_dataB = operand(ctrl_readRegB, data_readRegB);
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_valid", W'(out_valid), W'(m_valid));
            chk("m_regA", W'(out_regA), W'(m_regA));
            chk("m_regB", W'(out_regB), W'(m_regB));
            chk("m_dataA", out_dataA, m_dataA);
            chk("m_dataB", out_dataB, m_dataB);
            chk("m_cnt", W'(stall_count), W'(m_cnt));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; ctrl_writeEnable = 0;
        ctrl_writeReg = '0; data_writeReg = '0;
    endtask

    task automatic rd(input int ra, input logic [W-1:0] da,
                      input int rb, input logic [W-1:0] db);
        ctrl_readRegA = RB'(ra); data_readRegA = da;
        ctrl_readRegB = RB'(rb); data_readRegB = db;
    endtask

    task automatic wr(input int r, input logic [W-1:0] d);
        ctrl_writeEnable = 1; ctrl_writeReg = RB'(r); data_writeReg = d;
    endtask

    initial begin
        reset = 1; idle(); rd(0, '0, 0, '0);
        // Reset with random inputs
        repeat (2) begin
            in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            ctrl_writeEnable = 1'($urandom);
            rd($urandom_range(31), $urandom, $urandom_range(31), $urandom);
            ctrl_writeReg = RB'($urandom); data_writeReg = $urandom;
            tick();
        end
        chk("rst_valid", W'(out_valid), 0);
        chk("rst_dataA", out_dataA, 0);
        chk("rst_cnt", W'(stall_count), 0);
        reset = 0; idle();

        // Plain load
        in_valid = 1; rd(3, 32'h11, 7, 32'h22);
        tick();
        chk("load_valid", W'(out_valid), 1);
        chk("load_regA", W'(out_regA), 3);
        chk("load_dataA", out_dataA, 32'h11);
        chk("load_regB", W'(out_regB), 7);
        chk("load_dataB", out_dataB, 32'h22);

        // Zero register, write to reg 0 never bypasses
        rd(0, 32'hDEADBEEF, 4, 32'h44); wr(0, 32'h5);
        tick();
        chk("zero_dataA", out_dataA, 0);
        chk("zero_dataB", out_dataB, 32'h44);

        // Same-cycle write-back bypass on both ports
        rd(9, 32'h1, 9, 32'h1); wr(9, 32'hABCD);
        tick();
        chk("byp_dataA", out_dataA, BYP ? 32'hABCD : 32'h1);
        chk("byp_dataB", out_dataB, BYP ? 32'hABCD : 32'h1);

        // Stall with invalid stage does not count
        idle(); reset = 1; tick(); reset = 0;
        stall = 1; repeat (2) tick();
        chk("stall_inv_cnt", W'(stall_count), 0);

        // Load reg 5 then stall 3 cycles, write reg 5 in cycle 2
        stall = 0; in_valid = 1; rd(5, 32'h10, 6, 32'h20);
        tick();
        in_valid = 0; stall = 1; rd(12, 32'h99, 5, 32'h98);
        tick();
        wr(5, 32'h77);
        tick();
        ctrl_writeEnable = 0;
        tick();
        chk("stall_cnt3", W'(stall_count), 3);
        chk("stall_valid", W'(out_valid), 1);
        chk("stall_regA", W'(out_regA), 5);
        chk("stall_dataA", out_dataA, BYP ? 32'h77 : 32'h10);
        chk("stall_dataB", out_dataB, 32'h20);

        // Saturation: reach max-2 then 5 more stalls
        repeat (10) tick();
        chk("sat_pre", W'(stall_count), 13);
        repeat (5) tick();
        chk("sat_max", W'(stall_count), 15);

        // Flush with stall on the same edge
        flush = 1;
        tick();
        chk("flush_valid", W'(out_valid), 0);
        chk("flush_dataA", out_dataA, 0);
        chk("flush_dataB", out_dataB, 0);
        chk("flush_cnt", W'(stall_count), 15);
        flush = 0; stall = 0; in_valid = 1; rd(2, 32'h5A, 0, 32'h3C);
        tick();
        chk("post_valid", W'(out_valid), 1);
        chk("post_dataA", out_dataA, 32'h5A);
        chk("post_dataB", out_dataB, 0);

        // Reset asserted mid-stall discards held operands
        in_valid = 0; stall = 1;
        tick();
        reset = 1;
        tick();
        chk("rst_stall_valid", W'(out_valid), 0);
        chk("rst_stall_dataA", out_dataA, 0);
        chk("rst_stall_cnt", W'(stall_count), 0);
        reset = 0; idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
